wb_mem_tester: RTL
==================

Name: wb_mem_tester

Overview:
- Wishbone 32-bit bus initiator (master) that exercises any Wishbone memory slave, such as the SSRAM bridge.
- Writes a generated data pattern over a word range, reads the range back, and compares each word.
- Reports pass/fail, a saturating error count and the first mismatch.
- Used for board bring-up and BIST of the external SSRAM path.

Parameters:
- TIMEOUT, 1024: cycles to wait for ack/err/rty per request before aborting (>=2).
- LFSR_SEED, 32'hACE1_2468: seed for pattern 2; must be nonzero.
- MAX_RTY, 15: consecutive rty responses allowed on one transfer before it counts as a failure.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; starts a test when idle.
- base_adr  in  32  byte address of the first word; bits [1:0] ignored (treated as 0).
- word_count  in  16  number of 32-bit words to test.
- pattern_sel  in  2  0=address, 1=~address, 2=LFSR, 3=alternating 32'h5555_5555/32'hAAAA_AAAA.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse at test end.
- pass  out  1  valid from done until the next start: no failures and no timeout.
- timeout  out  1  sticky until the next start; set when an abort occurred.
- fail_count  out  16  mismatches plus err/retry-exhausted transfers; saturates at 16'hFFFF.
- first_fail_adr  out  32  byte address of the first failure.
- first_fail_exp  out  32  expected data at the first failure.
- first_fail_got  out  32  read data at the first failure (0 for err or retry exhaustion).
- adr  out  32  Wishbone address.
- dout  out  32  Wishbone write data.
- din  in  32  Wishbone read data.
- cyc  out  1  Wishbone cycle.
- stb  out  1  Wishbone strobe.
- sel  out  4  byte selects; always 4'hF while stb is high, else 0.
- we  out  1  Wishbone write enable.
- ack  in  1  Wishbone acknowledge.
- err  in  1  Wishbone error.
- rty  in  1  Wishbone retry.

Behaviour:
- Reset values: all outputs 0 (adr, dout, sel, cyc, stb, we, busy, done, pass, timeout, fail_count, first_fail_*).
- Reset asserted mid-test aborts immediately; no done pulse is produced.
- States:
  - IDLE:
    - start with word_count!=0 -> latch inputs; load address, pattern generator and index=0 -> WR_REQ.
    - start with word_count==0 -> DONE with pass=1.
    - start while busy is ignored.
  - WR_REQ: drive cyc=stb=we=1, sel=F, adr=base+4*index, dout=pattern(index). Hold every signal stable until a response arrives.
  - WR_GAP: exactly one cycle with cyc=stb=we=0. Then index++; if index==word_count, reset index and regenerate pattern -> RD_REQ; else -> WR_REQ.
  - RD_REQ: as WR_REQ but we=0 and dout=0. On ack, compare din with pattern(index) in the same edge.
  - RD_GAP: one idle cycle, then index++; if index==word_count -> DONE, else -> RD_REQ.
  - DONE: done=1 for one cycle; busy=0; pass=(fail_count==0 && !timeout) -> IDLE.
- Bus response handling:
  - cyc/stb drop on the clock edge that samples the response, so the slave sees stb low in its post-ack cycle and never starts a duplicate transfer.
  - Priority when several responses arrive in one cycle: err > ack > rty.
  - err: counts as a failure; proceed to the GAP state.
  - rty: drop stb for one cycle, then reissue the identical transfer. After MAX_RTY consecutive rty responses, count a failure and proceed.
  - No response within TIMEOUT cycles of the request: set timeout, drop cyc/stb -> DONE. Remaining words are skipped.
- Failure capture:
  - first_fail_* loads only when fail_count==0 before the increment.
  - fail_count increments by 1 per failing word; it holds at FFFF and never wraps.
- Patterns:
  - Pattern 2 is a Galois LFSR, taps x^32+x^22+x^2+x+1, advanced once per word.
  - The LFSR is reloaded with LFSR_SEED at the start of each phase, so the read phase regenerates the write sequence.
  - Pattern 3 uses 5555_5555 for even index and AAAA_AAAA for odd index.
- Address arithmetic is modulo 2^32; wrap past FFFF_FFFC is allowed and silent.
- Minimum cost per word: 1 request cycle + slave latency + 1 gap cycle, per phase.

Decomposition:
- Shared package wb_mem_tester_pkg:
  - state encodings;
  - pattern_sel constants (PAT_ADR, PAT_NADR, PAT_LFSR, PAT_ALT);
  - LFSR tap mask.
- One sub-module, wb_mem_pattern_gen:
  - inputs: clk, rst_n, load, advance, pattern_sel, adr;
  - output: 32-bit pattern word;
  - contains the LFSR and the alternating toggle.

Test Plan:
- Zero-wait slave model, base=0x0000_0100, count=4, pattern 0 -> writes 0x100/0x104/0x108/0x10C with data equal to the address; 8 transfers total; done pulses once; pass=1; fail_count=0.
- Slave read data with bit 3 stuck at 0, count=2, pattern 1, base=0 -> word 0 expects FFFF_FFFF and gets FFFF_FFF7; fail_count=2; first_fail_adr=0, first_fail_exp=FFFF_FFFF, first_fail_got=FFFF_FFF7; pass=0.
- Slave that never responds, TIMEOUT=16 -> stb high exactly 16 cycles, then timeout=1, done pulses, pass=0, busy=0.
- Slave answers rty twice and then ack on the first write -> identical adr/dout reissued twice, each preceded by one stb-low cycle; pass=1.
- Pattern 2, count=3, slave with real storage -> the read phase compares the seed followed by two LFSR steps; pass=1. Drive rst_n low mid-read -> all outputs return to 0 and no done pulse.
- start pulsed while busy, and count=0 with pattern 3 -> the busy start is ignored; the count=0 start gives done one cycle later with pass=1 and no bus activity.

Source files
------------

// File: rtl/wb_mem_tester_pkg.sv
// Shared definitions for the Wishbone memory tester.
//   state_e      : controller state encoding
//   PAT_*        : pattern_sel encodings
//   LFSR_TAPS    : Galois feedback mask for x^32+x^22+x^2+x+1
package wb_mem_tester_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StWrReq,
      StWrRty,
      StWrGap,
      StRdReq,
      StRdRty,
      StRdGap,
      StDone
   } state_e;

   localparam logic [1:0] PAT_ADR  = 2'd0;
   localparam logic [1:0] PAT_NADR = 2'd1;
   localparam logic [1:0] PAT_LFSR = 2'd2;
   localparam logic [1:0] PAT_ALT  = 2'd3;

   // Right-shifting Galois form: bit k of the mask feeds term x^(k+1).
   localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

endpackage

// File: rtl/wb_mem_pattern_gen.sv
// Test data generator.
//   clk, rst_n   : clock, async active-low reset
//   load         : restart the sequence (LFSR := seed, word parity := even)
//   advance      : step to the next word
//   pattern_sel  : pattern kind (PAT_*)
//   adr          : current byte address, used by the address patterns
//   pattern      : data word for the current index
module wb_mem_pattern_gen
   import wb_mem_tester_pkg::*;
#(
   parameter logic [31:0] LFSR_SEED = 32'hACE1_2468
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load,
   input  logic        advance,
   input  logic [1:0]  pattern_sel,
   input  logic [31:0] adr,
   output logic [31:0] pattern
);

   logic [31:0] lfsr_q;
   logic        odd_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lfsr_q <= LFSR_SEED;
         odd_q  <= 1'b0;
      end else if (load) begin
         lfsr_q <= LFSR_SEED;
         odd_q  <= 1'b0;
      end else if (advance) begin
         lfsr_q <= (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_TAPS : 32'h0);
         odd_q  <= ~odd_q;
      end
   end

   always_comb begin
      pattern = adr;
      unique case (pattern_sel)
         PAT_ADR:  pattern = adr;
         PAT_NADR: pattern = ~adr;
         PAT_LFSR: pattern = lfsr_q;
         PAT_ALT:  pattern = odd_q ? 32'hAAAA_AAAA : 32'h5555_5555;
      endcase
   end

endmodule

// File: rtl/wb_mem_tester.sv
// Wishbone initiator that writes a pattern over a word range, reads it back and compares.
//   start/base_adr/word_count/pattern_sel : test request (start is a one-cycle pulse)
//   busy/done/pass/timeout                : test status
//   fail_count, first_fail_*              : failure statistics
//   adr/dout/din/cyc/stb/sel/we/ack/err/rty : Wishbone initiator port
module wb_mem_tester
   import wb_mem_tester_pkg::*;
#(
   parameter int unsigned TIMEOUT   = 1024,
   parameter logic [31:0] LFSR_SEED = 32'hACE1_2468,
   parameter int unsigned MAX_RTY   = 15
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [31:0] base_adr,
   input  logic [15:0] word_count,
   input  logic [1:0]  pattern_sel,
   output logic        busy,
   output logic        done,
   output logic        pass,
   output logic        timeout,
   output logic [15:0] fail_count,
   output logic [31:0] first_fail_adr,
   output logic [31:0] first_fail_exp,
   output logic [31:0] first_fail_got,
   output logic [31:0] adr,
   output logic [31:0] dout,
   input  logic [31:0] din,
   output logic        cyc,
   output logic        stb,
   output logic [3:0]  sel,
   output logic        we,
   input  logic        ack,
   input  logic        err,
   input  logic        rty
);

   localparam int unsigned TW = $clog2(TIMEOUT);
   localparam int unsigned RW = $clog2(MAX_RTY + 1);

   state_e        state_q, state_d;
   logic [31:0]   adr_q, adr_d;
   logic [31:0]   base_q, base_d;
   logic [15:0]   wc_q, wc_d;
   logic [15:0]   idx_q, idx_d;
   logic [1:0]    psel_q, psel_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic [RW-1:0] rty_q, rty_d;
   logic          timeout_q, timeout_d;
   logic          pass_q, pass_d;
   logic [15:0]   fail_q, fail_d;
   logic [31:0]   ff_adr_q, ff_adr_d;
   logic [31:0]   ff_exp_q, ff_exp_d;
   logic [31:0]   ff_got_q, ff_got_d;

   logic          pat_load, pat_adv;
   logic [31:0]   pattern;
   logic          rec_fail;
   logic [31:0]   rec_got;
   logic          is_rd, in_req;
   state_e        gap_st;

   wb_mem_pattern_gen #(
      .LFSR_SEED (LFSR_SEED)
   ) u_pattern_gen (
      .clk         (clk),
      .rst_n       (rst_n),
      .load        (pat_load),
      .advance     (pat_adv),
      .pattern_sel (psel_q),
      .adr         (adr_q),
      .pattern     (pattern)
   );

   assign is_rd  = (state_q == StRdReq);
   assign in_req = (state_q == StWrReq) || (state_q == StRdReq);
   assign gap_st = is_rd ? StRdGap : StWrGap;

   always_comb begin
      state_d   = state_q;
      adr_d     = adr_q;
      base_d    = base_q;
      wc_d      = wc_q;
      idx_d     = idx_q;
      psel_d    = psel_q;
      tmo_d     = tmo_q;
      rty_d     = rty_q;
      timeout_d = timeout_q;
      pass_d    = pass_q;
      fail_d    = fail_q;
      ff_adr_d  = ff_adr_q;
      ff_exp_d  = ff_exp_q;
      ff_got_d  = ff_got_q;
      pat_load  = 1'b0;
      pat_adv   = 1'b0;
      rec_fail  = 1'b0;
      rec_got   = 32'h0;

      unique case (state_q)
         StIdle: begin
            if (start) begin
               base_d    = base_adr & 32'hFFFF_FFFC;
               adr_d     = base_adr & 32'hFFFF_FFFC;
               wc_d      = word_count;
               psel_d    = pattern_sel;
               idx_d     = 16'h0;
               tmo_d     = '0;
               rty_d     = '0;
               timeout_d = 1'b0;
               fail_d    = 16'h0;
               ff_adr_d  = 32'h0;
               ff_exp_d  = 32'h0;
               ff_got_d  = 32'h0;
               pat_load  = 1'b1;
               if (word_count == 16'h0) begin
                  pass_d  = 1'b1;
                  state_d = StDone;
               end else begin
                  pass_d  = 1'b0;
                  state_d = StWrReq;
               end
            end
         end

         StWrReq, StRdReq: begin
            // Response priority: err > ack > rty.
            if (err) begin
               rec_fail = 1'b1;
               state_d  = gap_st;
            end else if (ack) begin
               if (is_rd && (din != pattern)) begin
                  rec_fail = 1'b1;
                  rec_got  = din;
               end
               state_d = gap_st;
            end else if (rty) begin
               tmo_d = '0;
               if (rty_q == RW'(MAX_RTY - 1)) begin
                  rec_fail = 1'b1;
                  state_d  = gap_st;
               end else begin
                  rty_d   = rty_q + RW'(1);
                  state_d = is_rd ? StRdRty : StWrRty;
               end
            end else if (tmo_q == TW'(TIMEOUT - 1)) begin
               timeout_d = 1'b1;
               pass_d    = 1'b0;
               state_d   = StDone;
            end else begin
               tmo_d = tmo_q + TW'(1);
            end
         end

         StWrRty: state_d = StWrReq;
         StRdRty: state_d = StRdReq;

         StWrGap: begin
            tmo_d = '0;
            rty_d = '0;
            if (idx_q == wc_q - 16'd1) begin
               idx_d    = 16'h0;
               adr_d    = base_q;
               pat_load = 1'b1;
               state_d  = StRdReq;
            end else begin
               idx_d   = idx_q + 16'd1;
               adr_d   = adr_q + 32'd4;
               pat_adv = 1'b1;
               state_d = StWrReq;
            end
         end

         StRdGap: begin
            tmo_d = '0;
            rty_d = '0;
            if (idx_q == wc_q - 16'd1) begin
               pass_d  = (fail_q == 16'h0) && !timeout_q;
               state_d = StDone;
            end else begin
               idx_d   = idx_q + 16'd1;
               adr_d   = adr_q + 32'd4;
               pat_adv = 1'b1;
               state_d = StRdReq;
            end
         end

         StDone: state_d = StIdle;

         default: state_d = StIdle;
      endcase

      if (rec_fail) begin
         if (fail_q == 16'h0) begin
            ff_adr_d = adr_q;
            ff_exp_d = pattern;
            ff_got_d = rec_got;
         end
         if (fail_q != 16'hFFFF) begin
            fail_d = fail_q + 16'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         adr_q     <= 32'h0;
         base_q    <= 32'h0;
         wc_q      <= 16'h0;
         idx_q     <= 16'h0;
         psel_q    <= PAT_ADR;
         tmo_q     <= '0;
         rty_q     <= '0;
         timeout_q <= 1'b0;
         pass_q    <= 1'b0;
         fail_q    <= 16'h0;
         ff_adr_q  <= 32'h0;
         ff_exp_q  <= 32'h0;
         ff_got_q  <= 32'h0;
      end else begin
         state_q   <= state_d;
         adr_q     <= adr_d;
         base_q    <= base_d;
         wc_q      <= wc_d;
         idx_q     <= idx_d;
         psel_q    <= psel_d;
         tmo_q     <= tmo_d;
         rty_q     <= rty_d;
         timeout_q <= timeout_d;
         pass_q    <= pass_d;
         fail_q    <= fail_d;
         ff_adr_q  <= ff_adr_d;
         ff_exp_q  <= ff_exp_d;
         ff_got_q  <= ff_got_d;
      end
   end

   // Bus outputs decode from the state register, so cyc/stb fall on the response edge.
   assign stb = in_req;
   assign cyc = in_req || (state_q == StWrRty) || (state_q == StRdRty);
   assign we  = (state_q == StWrReq) || (state_q == StWrRty);
   assign sel = in_req ? 4'hF : 4'h0;
   assign adr = adr_q;
   assign dout = we ? pattern : 32'h0;

   assign busy = (state_q != StIdle) && (state_q != StDone);
   assign done = (state_q == StDone);
   assign pass = pass_q;
   assign timeout = timeout_q;
   assign fail_count = fail_q;
   assign first_fail_adr = ff_adr_q;
   assign first_fail_exp = ff_exp_q;
   assign first_fail_got = ff_got_q;

endmodule
